mem_port_arbiter: RTL

- Shares one downstream memory/cache port (ufp-style: addr, rmask, wmask, rdata, wdata, resp) between the instruction-fetch requester (read-only) and the load/store requester (read/write).
- Requesters present single-cycle mask pulses and wait for resp. The arbiter captures each request, serialises them with one transaction outstanding downstream, and routes the response back.
- Data side has priority; a starvation counter bounds how long fetch waits.

---
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and downstream memory port signals of the arbiter.
// slave: the arbiter side. master: the requesters plus the memory model.
interface mem_port_arbiter_if;
    logic [31:0] i_addr;
    logic [3:0]  i_rmask;
    logic [31:0] i_rdata;
    logic        i_resp;

    logic [31:0] d_addr;
    logic [3:0]  d_rmask;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_resp;

    logic [31:0] m_addr;
    logic [3:0]  m_rmask;
    logic [3:0]  m_wmask;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_resp;

    logic        busy;

    modport slave (
        input  i_addr, i_rmask, d_addr, d_rmask, d_wmask, d_wdata, m_rdata, m_resp,
        output i_rdata, i_resp, d_rdata, d_resp, m_addr, m_rmask, m_wmask, m_wdata, busy
    );

    modport master (
        output i_addr, i_rmask, d_addr, d_rmask, d_wmask, d_wdata, m_rdata, m_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, m_addr, m_rmask, m_wmask, m_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between instruction fetch (read only)
// and load/store (read/write). Requests are captured from one-cycle mask
// pulses, one transaction is outstanding downstream at a time, and the
// response is steered back to the side that was granted. Data has priority;
// a saturating counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic              i_pend_q, i_pend_d;
    logic [31:0]       i_addr_q, i_addr_d;
    logic [3:0]        i_rmask_q, i_rmask_d;
    logic              d_pend_q, d_pend_d;
    logic [31:0]       d_addr_q, d_addr_d;
    logic [3:0]        d_rmask_q, d_rmask_d;
    logic [3:0]        d_wmask_q, d_wmask_d;
    logic [31:0]       d_wdata_q, d_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic i_req, d_req, grant_i, grant_d, i_done, d_done;

    // Request detection, arbitration decision and response completion.
    always_comb begin
        i_req   = |bus.i_rmask;
        d_req   = (|bus.d_rmask) | (|bus.d_wmask);
        grant_d = (state_q == IDLE) && d_pend_q && !(i_pend_q && (cnt_q == LIMIT));
        grant_i = (state_q == IDLE) && i_pend_q && !grant_d;
        i_done  = (state_q == WAIT_I) && bus.m_resp;
        d_done  = (state_q == WAIT_D) && bus.m_resp;
    end

    // All state flops; a transaction cut off by reset is simply abandoned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            i_pend_q  <= 1'b0;
            i_addr_q  <= '0;
            i_rmask_q <= '0;
            d_pend_q  <= 1'b0;
            d_addr_q  <= '0;
            d_rmask_q <= '0;
            d_wmask_q <= '0;
            d_wdata_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            i_pend_q  <= i_pend_d;
            i_addr_q  <= i_addr_d;
            i_rmask_q <= i_rmask_d;
            d_pend_q  <= d_pend_d;
            d_addr_q  <= d_addr_d;
            d_rmask_q <= d_rmask_d;
            d_wmask_q <= d_wmask_d;
            d_wdata_q <= d_wdata_d;
            cnt_q     <= cnt_d;
        end
    end

    // Request capture (a new request beats the clear in the resp cycle) and starvation count.
    always_comb begin
        i_pend_d  = i_pend_q;
        i_addr_d  = i_addr_q;
        i_rmask_d = i_rmask_q;
        d_pend_d  = d_pend_q;
        d_addr_d  = d_addr_q;
        d_rmask_d = d_rmask_q;
        d_wmask_d = d_wmask_q;
        d_wdata_d = d_wdata_q;
        cnt_d     = cnt_q;

        if (i_done) i_pend_d = 1'b0;
        if (i_req) begin
            i_pend_d  = 1'b1;
            i_addr_d  = bus.i_addr;
            i_rmask_d = bus.i_rmask;
        end

        if (d_done) d_pend_d = 1'b0;
        if (d_req) begin
            d_pend_d  = 1'b1;
            d_addr_d  = bus.d_addr;
            d_rmask_d = bus.d_rmask;
            d_wmask_d = bus.d_wmask;
            d_wdata_d = bus.d_wdata;
        end

        if (!i_pend_q || grant_i)           cnt_d = '0;
        else if (grant_d && cnt_q != LIMIT) cnt_d = cnt_q + 1'b1;
    end

    // Next-state: issue from IDLE, return to IDLE on the downstream response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d)      state_d = WAIT_D;
                else if (grant_i) state_d = WAIT_I;
            end
            WAIT_I:  if (bus.m_resp) state_d = IDLE;
            WAIT_D:  if (bus.m_resp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: masks only in the issue cycle, addr/wdata held while waiting, resp steered.
    always_comb begin
        bus.m_addr  = '0;
        bus.m_rmask = '0;
        bus.m_wmask = '0;
        bus.m_wdata = '0;
        bus.i_resp  = 1'b0;
        bus.i_rdata = '0;
        bus.d_resp  = 1'b0;
        bus.d_rdata = '0;
        bus.busy    = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    bus.m_addr  = d_addr_q;
                    bus.m_rmask = d_rmask_q;
                    bus.m_wmask = d_wmask_q;
                    bus.m_wdata = d_wdata_q;
                end else if (grant_i) begin
                    bus.m_addr  = i_addr_q;
                    bus.m_rmask = i_rmask_q;
                end
            end
            WAIT_I: begin
                bus.m_addr = i_addr_q;
                if (bus.m_resp) begin
                    bus.i_resp  = 1'b1;
                    bus.i_rdata = bus.m_rdata;
                end
            end
            WAIT_D: begin
                bus.m_addr  = d_addr_q;
                bus.m_wdata = d_wdata_q;
                if (bus.m_resp) begin
                    bus.d_resp  = 1'b1;
                    bus.d_rdata = bus.m_rdata;
                end
            end
            default: ;
        endcase
    end

`ifndef SYNTHESIS
    a_i_overlap: assert property (@(posedge clk) disable iff (!rst)
        i_req |-> (!i_pend_q || i_done));
    a_d_overlap: assert property (@(posedge clk) disable iff (!rst)
        d_req |-> (!d_pend_q || d_done));
    a_resp_idle: assert property (@(posedge clk) disable iff (!rst)
        bus.m_resp |-> (state_q != IDLE));
`endif

endmodule
